// File: rtl/trace_collector_pkg.sv
// trace_collector_pkg
//   Shared types and constants for the trace collector slice.
//   trace_item_t is the 128-bit item as seen on the stream port:
//   [127:112] lost_cnt, [111:96] skip_cnt, [95:64] instr, [63:0] pc.
package trace_collector_pkg;
   localparam int RISC_V_INSTRUCTION_WIDTH = 32;
   localparam int PC_WIDTH                 = 64;
   localparam int CNT_FIELD_WIDTH          = 16;
   localparam int TRACE_ITEM_WIDTH         = 128;

   typedef struct packed {
      logic [CNT_FIELD_WIDTH-1:0]          lost_cnt;
      logic [CNT_FIELD_WIDTH-1:0]          skip_cnt;
      logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
      logic [PC_WIDTH-1:0]                 pc;
   } trace_item_t;
endpackage

// File: rtl/trace_collector_if.sv
// trace_collector_if
//   AXI-Stream-style item channel towards the host DMA.
//   master: drives tdata/tvalid/tlast, samples tready.
//   slave : the reverse.
interface trace_collector_if;
   import trace_collector_pkg::*;

   logic [TRACE_ITEM_WIDTH-1:0] tdata;
   logic                        tvalid;
   logic                        tready;
   logic                        tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo
//   Synchronous show-ahead FIFO: rdata always presents the head entry.
//   Ports: clk, rst_n (sync, active low), push/wdata, pop/rdata,
//          full, empty, count (0..DEPTH).
//   The caller qualifies push/pop; push while full is legal only together
//   with a pop, since the write lands on the slot being vacated.
module trace_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);
endmodule

// File: rtl/trace_collector.sv
// trace_collector
//   Consumer end of the trace filter. Kept {pc, instr} events become
//   128-bit items (with the skip/lost counters captured before the event's
//   own update), are buffered in a show-ahead FIFO and leave on a stream
//   port with tlast framing every PACKET_ITEMS items or on flush.
//   Ports: clk, rst_n (sync, active low); pc_valid/pc/instr/drop_instr
//          event input; flush pulse; m (stream master); fifo_full status;
//          lost_total (wrapping count of events lost to a full FIFO).
module trace_collector import trace_collector_pkg::*; #(
   parameter int FIFO_DEPTH     = 16,
   parameter int PACKET_ITEMS   = 8,
   parameter int SKIP_CNT_WIDTH = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                pc_valid,
   input  logic [PC_WIDTH-1:0]                 pc,
   input  logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr,
   input  logic                                drop_instr,
   input  logic                                flush,
   trace_collector_if.master                   m,
   output logic                                fifo_full,
   output logic [31:0]                         lost_total
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = (PACKET_ITEMS > 1) ? $clog2(PACKET_ITEMS) : 1;
   localparam logic [PW-1:0]             PKT_LAST = PW'(PACKET_ITEMS - 1);
   localparam logic [SKIP_CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [AW:0]               CNT_ONE  = (AW+1)'(1);

   logic [SKIP_CNT_WIDTH-1:0] skip_cnt;
   logic [SKIP_CNT_WIDTH-1:0] lost_cnt;
   logic [PW-1:0]             pkt_cnt;
   logic                      flush_pending;

   logic        push_req, push_ok, pop, tlast;
   logic        empty, full, remains;
   logic [AW:0] count;
   trace_item_t item_in;
   trace_item_t item_out;

   assign push_req = pc_valid && !drop_instr;
   assign pop      = !empty && m.tready;
   // A full FIFO still takes the event if the head leaves this cycle.
   assign push_ok  = push_req && (!full || pop);

   assign item_in.lost_cnt = CNT_FIELD_WIDTH'(lost_cnt);
   assign item_in.skip_cnt = CNT_FIELD_WIDTH'(skip_cnt);
   assign item_in.instr    = instr;
   assign item_in.pc       = pc;

   trace_fifo #(.WIDTH(TRACE_ITEM_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_ok),
      .wdata (item_in),
      .pop   (pop),
      .rdata (item_out),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Flush closes the frame on the last buffered item, but only while no
   // new item is arriving behind it; otherwise tlast moves to the newcomer.
   always_comb begin
      tlast = 1'b0;
      if (!empty)
         tlast = (pkt_cnt == PKT_LAST) ||
                 (flush_pending && count == CNT_ONE && !push_ok);
   end

   // Something will still be buffered after this edge; a flush with nothing
   // left to frame is dropped so flush_pending never waits on an empty FIFO.
   assign remains = push_ok || (count > (AW+1)'(pop));

   assign m.tvalid  = !empty;
   assign m.tdata   = item_out;
   assign m.tlast   = tlast;
   assign fifo_full = full;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         skip_cnt      <= '0;
         lost_cnt      <= '0;
         lost_total    <= '0;
         pkt_cnt       <= '0;
         flush_pending <= 1'b0;
      end else begin
         if (pc_valid) begin
            if (drop_instr) begin
               if (skip_cnt != CNT_MAX) skip_cnt <= skip_cnt + 1'b1;
            end else if (push_ok) begin
               skip_cnt <= '0;
               lost_cnt <= '0;
            end else begin
               if (lost_cnt != CNT_MAX) lost_cnt <= lost_cnt + 1'b1;
               lost_total <= lost_total + 32'd1;
            end
         end

         if (pop) pkt_cnt <= tlast ? '0 : pkt_cnt + 1'b1;

         if (pop && tlast)
            flush_pending <= 1'b0;
         if (flush && !flush_pending && remains)
            flush_pending <= 1'b1;
      end
   end
endmodule
